valid_ready_in_order_retire_stage: RTL and testbench
====================================================

Name: valid_ready_in_order_retire_stage

Overview:
Downstream companion to the out-of-order buffer.
- Records buffer indices in allocation order.
- Accepts completion marks for those indices in any order.
- Drains the buffer strictly in allocation order: issues an indexed read-with-clear for the oldest index once it is complete.
- Presents the data on a registered valid-ready retire port, for example to restore program order after out-of-order execution.

Parameters:
WIDTH, 8, data width; must match the buffer's WIDTH.
DEPTH, 8, number of trackable indices; must match the buffer's DEPTH.
INDEX_WIDTH, $clog2(DEPTH), index width.
COUNT_WIDTH, $clog2(DEPTH+1), width of the pending count.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
allocate_valid  input  1  buffer write handshake occurred; capture index.
allocate_index  input  INDEX_WIDTH  index returned by the buffer write.
allocate_ready  output  1  order queue not full.
complete_valid  input  1  completion mark strobe.
complete_index  input  INDEX_WIDTH  index being marked complete.
complete_error  output  1  one-cycle pulse: illegal completion.
buffer_read_valid  output  1  indexed read request to the buffer.
buffer_read_clear  output  1  always equal to buffer_read_valid; frees the entry.
buffer_read_index  output  INDEX_WIDTH  oldest pending index.
buffer_read_data  input  WIDTH  combinational read data from the buffer.
buffer_read_ready  input  1  buffer accepts the read.
buffer_read_error  input  1  buffer flags a read of an invalid entry.
retire_valid  output  1  retire output holds data.
retire_data  output  WIDTH  retired data.
retire_index  output  INDEX_WIDTH  index the data came from.
retire_error  output  1  buffer_read_error captured with this data.
retire_ready  input  1  consumer accepts.
pending_count  output  COUNT_WIDTH  indices allocated and not yet retired.
empty  output  1  pending_count == 0.
full  output  1  pending_count == DEPTH.

Behaviour:
Interface (already decided):
- One clock; reset is asynchronous and active-high.

Reset:
- Order queue empty, done bitmap cleared, output register empty.
- retire_valid=0, retire_data=0, retire_index=0, retire_error=0.
- complete_error=0, buffer_read_valid=0, pending_count=0, empty=1, full=0, allocate_ready=1.
- Reset asserted mid-operation discards all tracking immediately. The buffer must be reset together with this block.

Order queue:
- Circular FIFO of DEPTH indices; read/write pointers are INDEX_WIDTH+1 bits with a wrap bit.
- Push when allocate_valid & allocate_ready.
- allocate_ready = ~full. There is no same-cycle push on a full queue, even if a pop occurs in that cycle.
- allocate_valid while full: ignored, no state change.

Done bitmap:
- One bit per index, plus a pending bitmap (set on push, cleared on pop).
- Completion check uses the registered state at the start of the cycle.
- complete_valid for an index that is not pending, or already done: bitmap unchanged; complete_error pulses high the next cycle.
- Completion and allocation of the same index in the same cycle: the completion is illegal (index not yet pending) and raises an error.

Issue:
- Head is valid when the queue is non-empty and done[head] is set at the start of the cycle.
- buffer_read_valid = head_done & (~retire_valid | retire_ready).
- On buffer_read_valid & buffer_read_ready, in the same cycle:
  - pop the queue;
  - clear done[head] and pending[head];
  - load the output register with buffer_read_data, head index and buffer_read_error.
- At most one retire per cycle.
- Simultaneous push and pop: pending_count unchanged.

Latency:
- Completion of the head index at cycle N: done set at N+1, read issued at N+1, retire_valid=1 at N+2.

Retire output:
- retire_valid holds until retire_ready.
- Data stays stable while retire_valid & ~retire_ready.
- Full throughput: one retire per cycle when the head is continuously done and retire_ready=1.

Wrap-around:
- Pointer wrap bits distinguish full from empty after DEPTH pushes.

Optional Feature:
Macro: RETIRE_BYPASS_EN
- Defined: a completion that targets the current head, and is legal, counts as done in the same cycle. The read is issued that cycle and retire_valid rises at N+1. The done bit is not set for that index.
- Undefined: the completion registers first, giving the N+2 latency above.
- Error detection is identical in both builds.

Test Plan:
1. Allocate 3, 5, 1; complete 1, 5, 3; retire_ready=1 -> retire_index sequence 3, 5, 1. First retire_valid two cycles after complete(3), or one cycle with RETIRE_BYPASS_EN.
2. Allocate 8 indices; 9th allocate_valid -> allocate_ready=0, full=1, pending_count=8, queue unchanged. Retire one -> allocate_ready=1 the next cycle.
3. Complete index 6 never allocated -> complete_error=1 for exactly one cycle, bitmap and outputs unchanged. Complete an index twice -> second completion errors.
4. Head done, retire_ready=0 for 4 cycles -> retire_valid=1 with retire_data stable, buffer_read_valid=0, no pop. Then retire_ready=1 -> next head retires back-to-back.
5. buffer_read_error=1 on a read of index 2 -> retire_error=1 with retire_index=2; the entry is still popped.
6. Reset asserted with 4 pending and retire_valid=1 -> all outputs at reset values immediately; post-reset allocate 0 -> pending_count=1.

Source files
------------

// File: rtl/valid_ready_in_order_retire_stage.sv
// ---------------------------------------------------------------------------
// valid_ready_in_order_retire_stage
//
// Downstream companion to an out-of-order buffer.
// - Records buffer indices in the order they were allocated.
// - Accepts completion marks for those indices in any order.
// - Drains the buffer strictly oldest-first. Once the oldest index is
//   complete, it issues an indexed read-with-clear for that index.
// - Holds the read data in a registered valid/ready retire port.
//
// Optional feature (compile-time macro RETIRE_BYPASS_EN):
//   When defined, a legal completion that targets the current head counts
//   as done in the same cycle. This saves one cycle of retire latency.
//
// Ports:
//   clock, reset          single rising-edge clock, async active-high reset
//   allocate_*            index capture from the buffer write handshake
//   complete_valid/index  completion mark strobe
//   complete_error        one-cycle pulse one cycle after an illegal mark
//   buffer_read_*         indexed read-with-clear request to the buffer
//   retire_*              registered valid/ready output of retired data
//   pending_count, empty, full   occupancy of the order queue
//
// The order queue pointers carry an extra wrap bit. Equal index fields with
// different wrap bits mean full; identical pointers mean empty.
// ---------------------------------------------------------------------------
module valid_ready_in_order_retire_stage #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   allocate_valid,
    input  logic [INDEX_WIDTH-1:0] allocate_index,
    output logic                   allocate_ready,
    input  logic                   complete_valid,
    input  logic [INDEX_WIDTH-1:0] complete_index,
    output logic                   complete_error,
    output logic                   buffer_read_valid,
    output logic                   buffer_read_clear,
    output logic [INDEX_WIDTH-1:0] buffer_read_index,
    input  logic [WIDTH-1:0]       buffer_read_data,
    input  logic                   buffer_read_ready,
    input  logic                   buffer_read_error,
    output logic                   retire_valid,
    output logic [WIDTH-1:0]       retire_data,
    output logic [INDEX_WIDTH-1:0] retire_index,
    output logic                   retire_error,
    input  logic                   retire_ready,
    output logic [COUNT_WIDTH-1:0] pending_count,
    output logic                   empty,
    output logic                   full
);

    // ------------------------------------------------------------------
    // Order queue storage and pointers
    // ------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] order_mem [DEPTH];
    logic [INDEX_WIDTH:0]   wr_ptr_reg;
    logic [INDEX_WIDTH:0]   rd_ptr_reg;
    logic [COUNT_WIDTH-1:0] count_reg;

    logic                   pending_reg [DEPTH];
    logic                   done_reg    [DEPTH];

    logic                   complete_error_reg;
    logic                   retire_valid_reg;
    logic [WIDTH-1:0]       retire_data_reg;
    logic [INDEX_WIDTH-1:0] retire_index_reg;
    logic                   retire_error_reg;

    logic                   queue_empty;
    logic                   queue_full;
    logic                   push;
    logic                   pop;
    logic [INDEX_WIDTH-1:0] head_index;
    logic                   head_done;
    logic                   head_ready;
    logic                   bypass_hit;
    logic                   complete_legal;
    logic                   complete_set;
    logic                   read_valid;

    // Advance a pointer. The wrap bit toggles when the index field passes
    // DEPTH-1. This also works when DEPTH is not a power of two.
    function automatic logic [INDEX_WIDTH:0] next_ptr(input logic [INDEX_WIDTH:0] p);
        logic [INDEX_WIDTH:0] n;
        if (p[INDEX_WIDTH-1:0] == INDEX_WIDTH'(DEPTH - 1)) begin
            n = {~p[INDEX_WIDTH], {INDEX_WIDTH{1'b0}}};
        end else begin
            n = p + 1'b1;
        end
        return n;
    endfunction

    assign queue_empty = (wr_ptr_reg == rd_ptr_reg);
    assign queue_full  = (wr_ptr_reg[INDEX_WIDTH-1:0] == rd_ptr_reg[INDEX_WIDTH-1:0]) &&
                         (wr_ptr_reg[INDEX_WIDTH] != rd_ptr_reg[INDEX_WIDTH]);

    // A full queue never accepts a push. This holds even if a pop happens
    // in the same cycle, so allocate_ready depends only on registered state.
    assign push       = allocate_valid & ~queue_full;
    assign head_index = order_mem[rd_ptr_reg[INDEX_WIDTH-1:0]];

    // Legality uses only the state registered at the start of the cycle.
    // A same-cycle allocation of this index is therefore not pending yet.
    assign complete_legal = complete_valid & pending_reg[complete_index] &
                            ~done_reg[complete_index];

    assign head_done = ~queue_empty & done_reg[head_index];

`ifdef RETIRE_BYPASS_EN
    assign bypass_hit = complete_legal & ~queue_empty & (complete_index == head_index);
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_ready = head_done | bypass_hit;
    assign read_valid = head_ready & (~retire_valid_reg | retire_ready);
    assign pop        = read_valid & buffer_read_ready;

    // A bypassed completion that is consumed by a read this cycle does not
    // set the done bit. If the read stalls, the completion is recorded as
    // usual so it is not lost.
    assign complete_set = complete_legal & ~(bypass_hit & pop);

    // ------------------------------------------------------------------
    // Order queue
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            order_mem[wr_ptr_reg[INDEX_WIDTH-1:0]] <= allocate_index;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-index pending and done bits
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_track
        // If a push and a pop hit the same index in one cycle, the push
        // wins. The old instance of that index retires and the new one
        // becomes pending.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                pending_reg[gi] <= 1'b0;
            end else if (push && (allocate_index == INDEX_WIDTH'(gi))) begin
                pending_reg[gi] <= 1'b1;
            end else if (pop && (head_index == INDEX_WIDTH'(gi))) begin
                pending_reg[gi] <= 1'b0;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                done_reg[gi] <= 1'b0;
            end else if (pop && (head_index == INDEX_WIDTH'(gi))) begin
                done_reg[gi] <= 1'b0;
            end else if (complete_set && (complete_index == INDEX_WIDTH'(gi))) begin
                done_reg[gi] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion error pulse and retire output register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            complete_error_reg <= 1'b0;
            retire_valid_reg   <= 1'b0;
            retire_data_reg    <= '0;
            retire_index_reg   <= '0;
            retire_error_reg   <= 1'b0;
        end else begin
            complete_error_reg <= complete_valid & ~complete_legal;
            if (pop) begin
                retire_valid_reg <= 1'b1;
                retire_data_reg  <= buffer_read_data;
                retire_index_reg <= head_index;
                retire_error_reg <= buffer_read_error;
            end else if (retire_ready) begin
                retire_valid_reg <= 1'b0;
            end
        end
    end

    assign allocate_ready    = ~queue_full;
    assign complete_error    = complete_error_reg;
    assign buffer_read_valid = read_valid;
    assign buffer_read_clear = read_valid;
    assign buffer_read_index = head_index;
    assign retire_valid      = retire_valid_reg;
    assign retire_data       = retire_data_reg;
    assign retire_index      = retire_index_reg;
    assign retire_error      = retire_error_reg;
    assign pending_count     = count_reg;
    assign empty             = queue_empty;
    assign full              = queue_full;

endmodule

// File: tb/tb_valid_ready_in_order_retire_stage.sv
module tb_valid_ready_in_order_retire_stage;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          allocate_valid = 1'b0;
    logic [IW-1:0] allocate_index = '0;
    logic          allocate_ready;
    logic          complete_valid = 1'b0;
    logic [IW-1:0] complete_index = '0;
    logic          complete_error;
    logic          buffer_read_valid;
    logic          buffer_read_clear;
    logic [IW-1:0] buffer_read_index;
    logic [W-1:0]  buffer_read_data;
    logic          buffer_read_ready = 1'b1;
    logic          buffer_read_error;
    logic          retire_valid;
    logic [W-1:0]  retire_data;
    logic [IW-1:0] retire_index;
    logic          retire_error;
    logic          retire_ready = 1'b1;
    logic [CW-1:0] pending_count;
    logic          empty;
    logic          full;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
        logic          err;
    } ent_t;

    ent_t exp_q[$];
    ent_t obs[$];
    int   obs_rd = 0;

    // Simple buffer model: per-index data and error flag with a
    // combinational read.
    logic [W-1:0] buf_data [D];
    logic         buf_err  [D];

    assign buffer_read_data  = buf_data[buffer_read_index];
    assign buffer_read_error = buf_err[buffer_read_index];

    always #5 clock = ~clock;

    valid_ready_in_order_retire_stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clock             (clock),
        .reset             (reset),
        .allocate_valid    (allocate_valid),
        .allocate_index    (allocate_index),
        .allocate_ready    (allocate_ready),
        .complete_valid    (complete_valid),
        .complete_index    (complete_index),
        .complete_error    (complete_error),
        .buffer_read_valid (buffer_read_valid),
        .buffer_read_clear (buffer_read_clear),
        .buffer_read_index (buffer_read_index),
        .buffer_read_data  (buffer_read_data),
        .buffer_read_ready (buffer_read_ready),
        .buffer_read_error (buffer_read_error),
        .retire_valid      (retire_valid),
        .retire_data       (retire_data),
        .retire_index      (retire_index),
        .retire_error      (retire_error),
        .retire_ready      (retire_ready),
        .pending_count     (pending_count),
        .empty             (empty),
        .full              (full)
    );

    // Record every retire handshake seen at a clock edge.
    always @(posedge clock) begin
        if (!reset && retire_valid && retire_ready) begin
            obs.push_back({retire_index, retire_data, retire_error});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic alloc(input logic [IW-1:0] i, input logic e);
        ent_t x;
        buf_data[i] = 8'($urandom_range(0, 255));
        buf_err[i]  = e;
        x = {i, buf_data[i], e};
        exp_q.push_back(x);
        allocate_valid = 1'b1;
        allocate_index = i;
        tick();
        allocate_valid = 1'b0;
    endtask

    task automatic complete(input logic [IW-1:0] i);
        complete_valid = 1'b1;
        complete_index = i;
        tick();
        complete_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL reset_retire_valid: got %b want 0", retire_valid); end
        checks++; if (retire_data !== 8'h00 || retire_index !== 3'd0 || retire_error !== 1'b0) begin
            errors++; $display("FAIL reset_retire_fields: got data=%h idx=%0d err=%b want 0", retire_data, retire_index, retire_error); end
        checks++; if (pending_count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL reset_occupancy: got count=%0d empty=%b full=%b want 0/1/0", pending_count, empty, full); end
        checks++; if (allocate_ready !== 1'b1 || buffer_read_valid !== 1'b0 || complete_error !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got ardy=%b brv=%b cerr=%b want 1/0/0", allocate_ready, buffer_read_valid, complete_error); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_order();
        ent_t e, o;
        retire_ready = 1'b1;
        alloc(3'd3, 1'b0);
        alloc(3'd5, 1'b0);
        alloc(3'd1, 1'b0);
        checks++; if (pending_count !== 4'd3) begin errors++; $display("FAIL order_count: got %0d want 3", pending_count); end
        complete(3'd1);
        complete(3'd5);
        complete(3'd3);
`ifdef RETIRE_BYPASS_EN
        checks++; if (retire_valid !== 1'b1 || retire_index !== 3'd3) begin
            errors++; $display("FAIL order_latency: got rv=%b idx=%0d want 1/3", retire_valid, retire_index); end
`else
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL order_latency_early: got rv=%b want 0", retire_valid); end
        tick();
        checks++; if (retire_valid !== 1'b1 || retire_index !== 3'd3) begin
            errors++; $display("FAIL order_latency: got rv=%b idx=%0d want 1/3", retire_valid, retire_index); end
`endif
        tick();
        checks++; if (retire_valid !== 1'b1 || retire_index !== 3'd5) begin
            errors++; $display("FAIL order_back_to_back: got rv=%b idx=%0d want 1/5", retire_valid, retire_index); end
        for (int w = 0; w < 40 && (obs.size() - obs_rd) < exp_q.size(); w++) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs.size()) begin
                errors++; $display("FAIL order_scoreboard: no retire seen, want idx=%0d", e.idx);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin errors++; $display("FAIL order_scoreboard: got idx=%0d data=%h err=%b want idx=%0d data=%h err=%b", o.idx, o.data, o.err, e.idx, e.data, e.err); end
            end
        end
        tick();
        checks++; if (empty !== 1'b1 || pending_count !== 4'd0) begin
            errors++; $display("FAIL order_empty: got empty=%b count=%0d want 1/0", empty, pending_count); end
    endtask

    task automatic test_full();
        ent_t e, o;
        retire_ready = 1'b1;
        for (int i = 0; i < D; i++) alloc(3'(i), 1'b0);
        checks++; if (full !== 1'b1 || pending_count !== 4'd8 || allocate_ready !== 1'b0) begin
            errors++; $display("FAIL full_state: got full=%b count=%0d ardy=%b want 1/8/0", full, pending_count, allocate_ready); end
        allocate_valid = 1'b1;
        allocate_index = 3'd0;
        tick();
        allocate_valid = 1'b0;
        checks++; if (pending_count !== 4'd8 || full !== 1'b1) begin
            errors++; $display("FAIL full_ignore: got count=%0d full=%b want 8/1", pending_count, full); end
        complete(3'd0);
        for (int w = 0; w < 6 && allocate_ready !== 1'b1; w++) tick();
        checks++; if (allocate_ready !== 1'b1 || pending_count !== 4'd7) begin
            errors++; $display("FAIL full_release: got ardy=%b count=%0d want 1/7", allocate_ready, pending_count); end
        for (int i = 1; i < D; i++) complete(3'(i));
        for (int w = 0; w < 40 && (obs.size() - obs_rd) < exp_q.size(); w++) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs.size()) begin
                errors++; $display("FAIL full_scoreboard: no retire seen, want idx=%0d", e.idx);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin errors++; $display("FAIL full_scoreboard: got idx=%0d data=%h err=%b want idx=%0d data=%h err=%b", o.idx, o.data, o.err, e.idx, e.data, e.err); end
            end
        end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained: got empty=%b want 1", empty); end
    endtask

    task automatic test_error();
        ent_t e, o;
        retire_ready = 1'b1;
        complete(3'd6);
        checks++; if (complete_error !== 1'b1) begin errors++; $display("FAIL error_unallocated: got %b want 1", complete_error); end
        checks++; if (pending_count !== 4'd0 || retire_valid !== 1'b0 || buffer_read_valid !== 1'b0) begin
            errors++; $display("FAIL error_no_effect: got count=%0d rv=%b brv=%b want 0/0/0", pending_count, retire_valid, buffer_read_valid); end
        tick();
        checks++; if (complete_error !== 1'b0) begin errors++; $display("FAIL error_one_cycle: got %b want 0", complete_error); end
        alloc(3'd2, 1'b0);
        complete(3'd2);
        checks++; if (complete_error !== 1'b0) begin errors++; $display("FAIL error_legal: got %b want 0", complete_error); end
        complete(3'd2);
        checks++; if (complete_error !== 1'b1) begin errors++; $display("FAIL error_double: got %b want 1", complete_error); end
        // Same-cycle allocation and completion of index 4.
        buf_data[4] = 8'($urandom_range(0, 255));
        buf_err[4]  = 1'b0;
        e = {3'd4, buf_data[4], 1'b0};
        exp_q.push_back(e);
        allocate_valid = 1'b1; allocate_index = 3'd4;
        complete_valid = 1'b1; complete_index = 3'd4;
        tick();
        allocate_valid = 1'b0; complete_valid = 1'b0;
        checks++; if (complete_error !== 1'b1) begin errors++; $display("FAIL error_same_cycle: got %b want 1", complete_error); end
        tick();
        checks++; if (pending_count !== 4'd1 || retire_valid !== 1'b0) begin
            errors++; $display("FAIL error_not_done: got count=%0d rv=%b want 1/0", pending_count, retire_valid); end
        complete(3'd4);
        for (int w = 0; w < 40 && (obs.size() - obs_rd) < exp_q.size(); w++) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs.size()) begin
                errors++; $display("FAIL error_scoreboard: no retire seen, want idx=%0d", e.idx);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin errors++; $display("FAIL error_scoreboard: got idx=%0d data=%h err=%b want idx=%0d data=%h err=%b", o.idx, o.data, o.err, e.idx, e.data, e.err); end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ent_t e, o;
        retire_ready = 1'b0;
        alloc(3'd1, 1'b0);
        alloc(3'd2, 1'b0);
        alloc(3'd3, 1'b0);
        complete(3'd1);
        complete(3'd2);
        complete(3'd3);
        for (int w = 0; w < 6 && retire_valid !== 1'b1; w++) tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (retire_valid !== 1'b1 || retire_index !== 3'd1 || retire_data !== exp_q[0].data ||
                buffer_read_valid !== 1'b0 || pending_count !== 4'd2) begin
                errors++; $display("FAIL stall_hold cycle %0d: got rv=%b idx=%0d data=%h brv=%b count=%0d want 1/1/%h/0/2",
                                   c, retire_valid, retire_index, retire_data, buffer_read_valid, pending_count, exp_q[0].data);
            end
            tick();
        end
        retire_ready = 1'b1;
        tick();
        checks++; if (retire_valid !== 1'b1 || retire_index !== 3'd2) begin
            errors++; $display("FAIL b2b_second: got rv=%b idx=%0d want 1/2", retire_valid, retire_index); end
        tick();
        checks++; if (retire_valid !== 1'b1 || retire_index !== 3'd3) begin
            errors++; $display("FAIL b2b_third: got rv=%b idx=%0d want 1/3", retire_valid, retire_index); end
        tick();
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got rv=%b want 0", retire_valid); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs.size()) begin
                errors++; $display("FAIL b2b_scoreboard: no retire seen, want idx=%0d", e.idx);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin errors++; $display("FAIL b2b_scoreboard: got idx=%0d data=%h err=%b want idx=%0d data=%h err=%b", o.idx, o.data, o.err, e.idx, e.data, e.err); end
            end
        end
    endtask

    task automatic test_read_error();
        ent_t e, o;
        retire_ready = 1'b1;
        alloc(3'd2, 1'b1);
        complete(3'd2);
        for (int w = 0; w < 6 && retire_valid !== 1'b1; w++) tick();
        checks++; if (retire_valid !== 1'b1 || retire_error !== 1'b1 || retire_index !== 3'd2) begin
            errors++; $display("FAIL read_error: got rv=%b err=%b idx=%0d want 1/1/2", retire_valid, retire_error, retire_index); end
        checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL read_error_pop: got count=%0d want 0", pending_count); end
        buf_err[2] = 1'b0;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs.size()) begin
                errors++; $display("FAIL rderr_scoreboard: no retire seen, want idx=%0d", e.idx);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin errors++; $display("FAIL rderr_scoreboard: got idx=%0d data=%h err=%b want idx=%0d data=%h err=%b", o.idx, o.data, o.err, e.idx, e.data, e.err); end
            end
        end
    endtask

    task automatic test_reset_mid();
        ent_t e, o;
        retire_ready = 1'b0;
        for (int i = 0; i < 5; i++) alloc(3'(i), 1'b0);
        complete(3'd0);
        for (int w = 0; w < 6 && retire_valid !== 1'b1; w++) tick();
        checks++; if (retire_valid !== 1'b1 || pending_count !== 4'd4) begin
            errors++; $display("FAIL mid_setup: got rv=%b count=%0d want 1/4", retire_valid, pending_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (retire_valid !== 1'b0 || retire_data !== 8'h00 || pending_count !== 4'd0 || empty !== 1'b1 ||
                      full !== 1'b0 || allocate_ready !== 1'b1 || buffer_read_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got rv=%b data=%h count=%0d empty=%b full=%b ardy=%b brv=%b want 0/00/0/1/0/1/0",
                               retire_valid, retire_data, pending_count, empty, full, allocate_ready, buffer_read_valid); end
        tick();
        reset = 1'b0;
        exp_q.delete();
        obs_rd = obs.size();
        retire_ready = 1'b1;
        alloc(3'd0, 1'b0);
        checks++; if (pending_count !== 4'd1) begin errors++; $display("FAIL post_reset_count: got %0d want 1", pending_count); end
        complete(3'd0);
        for (int w = 0; w < 40 && (obs.size() - obs_rd) < exp_q.size(); w++) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs.size()) begin
                errors++; $display("FAIL post_reset_scoreboard: no retire seen, want idx=%0d", e.idx);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin errors++; $display("FAIL post_reset_scoreboard: got idx=%0d data=%h err=%b want idx=%0d data=%h err=%b", o.idx, o.data, o.err, e.idx, e.data, e.err); end
            end
        end
        tick();
        checks++; if (obs.size() != obs_rd || empty !== 1'b1) begin
            errors++; $display("FAIL final_idle: got extra_retires=%0d empty=%b want 0/1", obs.size() - obs_rd, empty); end
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            buf_data[i] = '0;
            buf_err[i]  = 1'b0;
        end
        test_reset();
        test_order();
        test_full();
        test_error();
        test_back_to_back();
        test_read_error();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end want end");
        $fatal(1);
    end

endmodule
